// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, execute (redirect)
// and decode. The master modport is the fetch unit's view.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit
// limit (in-flight + buffered <= DEPTH), buffers returned words with their PCs
// and hands them to decode. A redirect flushes the buffer and marks every
// outstanding response for discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_kill;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [63:0]   r_mem [DEPTH];

    logic [CW:0]   w_occupancy;
    logic          w_redirect;
    logic [31:0]   w_redirect_pc;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_rsp_ok;
    logic          w_push;
    logic          w_instr_valid;
    logic          w_pop;

    assign w_redirect    = bus.redirect_valid;
    assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    assign w_occupancy   = {1'b0, r_inflight} + {1'b0, r_count};

    // A redirect drops the request combinationally; otherwise issue while credit remains.
    assign w_req_valid   = !rst && !w_redirect && (w_occupancy < DEPTH_C);
    assign w_accept      = w_req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign w_rsp_ok      = bus.imem_rsp_valid && (r_inflight != '0);
    assign w_push        = w_rsp_ok && (r_kill == '0) && !w_redirect;

    // Popping is gated by redirect so a flush cycle never moves the read pointer.
    assign w_instr_valid = !rst && (r_count != '0);
    assign w_pop         = w_instr_valid && bus.instr_ready && !w_redirect;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr_valid    = w_instr_valid;
    assign bus.instr          = r_mem[r_rd_ptr][31:0];
    assign bus.instr_pc       = r_mem[r_rd_ptr][63:32];

    // PC, response PC, credit and discard bookkeeping plus FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_kill     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (w_redirect) begin
            r_pc       <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_inflight <= r_inflight - CW'(w_rsp_ok);
            r_kill     <= r_inflight - CW'(w_rsp_ok);
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_rsp_ok && (r_kill != '0)) begin
                r_kill <= r_kill - CW'(1);
            end
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_rsp_ok);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage; contents need no reset because count qualifies the head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_rsp_pc, bus.imem_rsp_data};
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small in-order memory model with
// configurable latency answers requests with addr ^ 32'hA5A5_0000.
module tb_fetch_unit;
    logic clk;
    logic rst;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [63:0] got[$];
    logic [31:0] acc[$];
    int          cyc;
    int          lat;
    bit          mem_ready;
    int          n_chk;
    int          n_fail;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {pc, pc ^ 32'hA5A5_0000};
    endfunction

    // Drive memory for this cycle, let combinational outputs settle, log handshakes.
    task automatic cycle_begin();
        bus.imem_req_ready = mem_ready;
        if (rst) begin
            pend.delete();
            bus.imem_rsp_valid = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = pend[0].addr ^ 32'hA5A5_0000;
            void'(pend.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
        end
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back(req_t'{bus.imem_req_addr, cyc + lat});
            acc.push_back(bus.imem_req_addr);
        end
        if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid)
            got.push_back({bus.instr_pc, bus.instr});
    endtask

    task automatic cycle_end();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            cycle_end();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle_begin();
            chk("rst_req_valid", bus.imem_req_valid, 0);
            chk("rst_instr_valid", bus.instr_valid, 0);
            cycle_end();
        end
        rst = 1'b0;
        pend.delete();
        got.delete();
        acc.delete();
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        lat = 1;
        mem_ready = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b1;
        @(negedge clk);

        // Streaming from reset
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cycle_begin();
            if (k == 0) begin
                chk("s_first_req_valid", bus.imem_req_valid, 1);
                chk("s_first_req_addr", bus.imem_req_addr, 32'h0);
            end
            if (k < 2) begin
                chk("s_early_valid", bus.instr_valid, 0);
            end else begin
                chk("s_valid", bus.instr_valid, 1);
                chk("s_entry", {bus.instr_pc, bus.instr}, ent(32'(4 * (k - 2))));
            end
            cycle_end();
        end

        // Backpressure
        bus.instr_ready = 1'b0;
        do_reset();
        run(10);
        chk("bp_accepts", acc.size(), 4);
        cycle_begin();
        chk("bp_req_valid", bus.imem_req_valid, 0);
        chk("bp_head_valid", bus.instr_valid, 1);
        chk("bp_head_pc", bus.instr_pc, 32'h0);
        cycle_end();
        bus.instr_ready = 1'b1;
        got.delete();
        run(5);
        chk("bp_pop_count", got.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("bp_pop", got[i], ent(32'(4 * i)));

        // Redirect with two requests in flight, latency 3
        lat = 3;
        do_reset();
        run(2);
        chk("ri_accepts", acc.size(), 2);
        mem_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        cycle_begin();
        chk("ri_req_dropped", bus.imem_req_valid, 0);
        cycle_end();
        bus.redirect_valid = 1'b0;
        mem_ready = 1'b1;
        cycle_begin();
        chk("ri_req_valid", bus.imem_req_valid, 1);
        chk("ri_req_addr", bus.imem_req_addr, 32'h0000_0200);
        chk("ri_empty", bus.instr_valid, 0);
        cycle_end();
        for (int i = 0; i < 3; i++) begin
            cycle_begin();
            chk("ri_stale_dropped", bus.instr_valid, 0);
            cycle_end();
        end
        run(2);
        chk("ri_pop_count", got.size(), 2);
        chk("ri_first", got[0], ent(32'h0000_0200));
        chk("ri_second", got[1], ent(32'h0000_0204));

        // Redirect coinciding with a response and a pop
        lat = 1;
        do_reset();
        run(4);
        got.delete();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        cycle_begin();
        chk("re_head_valid", bus.instr_valid, 1);
        cycle_end();
        bus.redirect_valid = 1'b0;
        cycle_begin();
        chk("re_req_addr", bus.imem_req_addr, 32'h0000_0100);
        chk("re_req_valid", bus.imem_req_valid, 1);
        chk("re_flushed", bus.instr_valid, 0);
        cycle_end();
        run(2);
        chk("re_pop_count", got.size(), 1);
        chk("re_first", got[0], ent(32'h0000_0100));

        // PC wrap
        acc.delete();
        got.delete();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        run(1);
        bus.redirect_valid = 1'b0;
        run(5);
        chk("w_acc0", acc[0], 32'hFFFF_FFFC);
        chk("w_acc1", acc[1], 32'h0000_0000);
        chk("w_pop_count", got.size(), 3);
        chk("w_pop0", got[0], ent(32'hFFFF_FFFC));
        chk("w_pop1", got[1], ent(32'h0000_0000));

        // Reset with three entries buffered
        bus.instr_ready = 1'b0;
        do_reset();
        run(3);
        mem_ready = 1'b0;
        run(2);
        cycle_begin();
        chk("mr_head_valid", bus.instr_valid, 1);
        chk("mr_head_pc", bus.instr_pc, 32'h0);
        chk("mr_req_addr", bus.imem_req_addr, 32'h0000_000C);
        cycle_end();
        mem_ready = 1'b1;
        bus.instr_ready = 1'b1;
        do_reset();
        cycle_begin();
        chk("mr_resume_valid", bus.imem_req_valid, 1);
        chk("mr_resume_addr", bus.imem_req_addr, 32'h0);
        chk("mr_empty", bus.instr_valid, 0);
        cycle_end();
        run(2);
        chk("mr_pop_count", got.size(), 1);
        chk("mr_first", got[0], ent(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. Holds the program counter, issues word-aligned requests to instruction memory over a valid/ready request channel, and buffers returned words with their PCs in a small FIFO. The FIFO presents `{instr, instr_pc}` to decode over a valid/ready handshake. On a control-flow redirect from execute, it flushes buffered and in-flight fetches and restarts at the new target.

## Interface

Parameters:
- `RESET_PC`, `32'h0000_0000`: first fetch address after reset; low two bits must be 0.
- `DEPTH`, `4`: combined capacity of the output FIFO plus in-flight requests; power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `imem_req_valid`, out, 1: a fetch request is presented.
- `imem_req_ready`, in, 1: memory accepts the request this cycle.
- `imem_req_addr`, out, 32: byte address of the fetch; always word-aligned.
- `imem_rsp_valid`, in, 1: a response word is returned. Responses are in order, at least 1 cycle after acceptance.
- `imem_rsp_data`, in, 32: returned instruction word.
- `redirect_valid`, in, 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc`, in, 32: target address; bits [1:0] are ignored (treated as 0).
- `instr_valid`, out, 1: the FIFO head holds a valid instruction.
- `instr_ready`, in, 1: decode consumes the head this cycle.
- `instr`, out, 32: instruction word at the FIFO head.
- `instr_pc`, out, 32: PC of `instr`.

## Operation

State:
- `pc`: next fetch address.
- `rsp_pc`: PC of the next kept response.
- `inflight`: accepted requests with no response yet.
- `kill`: number of in-flight responses to discard.
- FIFO of `{pc, data}` entries, `DEPTH` deep, with an occupancy `count`.

Request issue:
- `imem_req_valid = !rst && !redirect_valid && (inflight + count < DEPTH)`.
- `imem_req_addr = pc`.
- Accept means `imem_req_valid && imem_req_ready`. On accept: `pc <= pc + 4` (mod 2^32, wraps from `0xFFFF_FFFC` to 0) and `inflight` increments.
- While valid is high and ready is low, the address holds. The only permitted withdrawal is a redirect, which drops valid combinationally.

Response handling, when `imem_rsp_valid` is high:
- `inflight` decrements.
- If `kill > 0`: the word is dropped and `kill` decrements.
- Otherwise: `{rsp_pc, imem_rsp_data}` is pushed into the FIFO and `rsp_pc <= rsp_pc + 4`.
- If `imem_rsp_valid` arrives while `inflight == 0`, it is a protocol violation and is ignored with no state change.

Output:
- `instr_valid = (count != 0)`; `instr` and `instr_pc` come from the head.
- The head pops on `instr_valid && instr_ready`.
- Push and pop may occur in the same cycle. The credit rule guarantees the FIFO never overflows.

Redirect, when `redirect_valid` is high:
- No request is issued.
- The FIFO is flushed (`count <= 0`); a same-cycle pop is ignored.
- `pc <= {redirect_pc[31:2], 2'b00}`.
- `rsp_pc` takes the same value.
- `kill <= inflight - imem_rsp_valid`, so every outstanding response is discarded, including any that arrives this cycle.
- Back-to-back redirects: the last one wins, with `kill` recomputed each cycle.

Reset (`rst` high at a clock edge):
- `pc = rsp_pc = RESET_PC`.
- `inflight = kill = count = 0`.
- Responses arriving during or after reset for pre-reset requests are protocol violations. Memory is reset together with this block.

Output values in and after reset:
- `imem_req_valid = 0` during reset.
- `instr_valid = 0` during reset.
- `imem_req_addr = RESET_PC` after the reset edge.
- `instr` and `instr_pc` are don't-care while `instr_valid = 0`.

## Timing

- Request accepted in cycle N, response in N+1 (minimum), `instr_valid` high in N+2.
- First `imem_req_valid` comes in the first cycle with `rst` low.
- Throughput: one instruction per cycle with 1-cycle memory latency and decode always ready.
  - Holds for memory latencies up to `DEPTH-1` cycles.
- Redirect in cycle R: the request at the new target is offered in R+1. The earliest `instr_valid` with the new PC is R+3, given 1-cycle memory.
- No combinational path from `instr_ready` to any output.
- Combinational path from `redirect_valid` to `imem_req_valid` only.

## Test plan

- **Streaming from reset.** `RESET_PC=0`; `rst` high for 2 cycles; memory always ready, 1-cycle latency, returns `addr ^ 32'hA5A5_0000`; decode always ready. Required: `instr_pc` = 0, 4, 8, 12, 16 on consecutive cycles starting 2 cycles after the first request, each with the matching data.
- **Backpressure.** Hold `instr_ready=0`. Required: exactly 4 requests are accepted, then `imem_req_valid` stays 0 and the FIFO holds PCs 0–12. Release ready; required: pops of 0, 4, 8, 12 in order with no duplicates.
- **Redirect with in-flight.** Memory latency 3, two requests outstanding, pulse `redirect_valid` with `redirect_pc=0x200`. Required: both stale responses are dropped, the FIFO is empty, the next request address is `0x200`, and the next delivered `instr_pc` is `0x200`.
- **Redirect edge cases.** Redirect to `0x103` in the same cycle as a response and a pop. Required: the response is dropped, the pop is ignored, and fetch resumes at `0x100`.
- **PC wrap.** Redirect to `0xFFFF_FFFC`. Required: fetch addresses `0xFFFF_FFFC` then `0x0000_0000`.
- **Reset mid-stream.** Assert `rst` while 3 entries are buffered. Required: `instr_valid` and `imem_req_valid` are 0 during reset, and fetch resumes at `RESET_PC`.
